// File: rtl/mem_access_ctrl_pkg.sv
// Shared RAM access-mode encodings, controller state encoding and access-legality helpers
// for the data-RAM load/store controller.
package mem_access_ctrl_pkg;

  localparam logic [1:0] RAM_MODE_BYTE = 2'b00;
  localparam logic [1:0] RAM_MODE_HALF = 2'b01;
  localparam logic [1:0] RAM_MODE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } mac_state_t;

  // The undefined size code behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? RAM_MODE_WORD : size;
  endfunction

  // True when the RAM can serve the access in a single cycle.
  function automatic logic is_native(input logic [1:0] offset, input logic [1:0] size);
    logic ok;
    case (size)
      RAM_MODE_BYTE: ok = 1'b1;
      RAM_MODE_HALF: ok = (offset != 2'd3);
      default:       ok = (offset == 2'd0);
    endcase
    return ok;
  endfunction

  // Index of the last byte write of a split store.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    return (size == RAM_MODE_HALF) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/mem_load_merge.sv
// Combines two consecutive RAM words into the result of a misaligned load:
// the little-endian byte stream {hi,lo} is shifted down by the byte offset, then extended.
module mem_load_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] rdata
);

  logic [63:0] stream;
  logic [31:0] window;
  logic        unused_stream_hi;

  assign stream           = {hi, lo} >> {offset, 3'b000};
  assign window           = stream[31:0];
  assign unused_stream_hi = ^stream[63:32];

  always_comb begin
    rdata = window;
    case (size)
      RAM_MODE_BYTE: rdata = {{24{is_signed & window[7]}}, window[7:0]};
      RAM_MODE_HALF: rdata = {{16{is_signed & window[15]}}, window[15:0]};
      default:       rdata = window;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit driving the data-RAM port: one request at a time, native accesses in one
// RAM cycle, misaligned loads as two word reads and misaligned stores as byte writes.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_we,
  output logic [31:0] ram_r_addr,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic [1:0]  ram_rmode,
  output logic [1:0]  ram_wmode,
  output logic        ram_rsigned,
  input  logic [31:0] ram_r_data
);

  mac_state_t  state, state_nxt;

  logic        ready_nxt, resp_valid_nxt, resp_err_nxt, ram_we_nxt, ram_rsigned_nxt;
  logic [31:0] resp_rdata_nxt, ram_r_addr_nxt, ram_w_addr_nxt, ram_w_data_nxt;
  logic [1:0]  ram_rmode_nxt, ram_wmode_nxt;

  logic [31:0] addr_p1, addr_nxt;
  logic [31:0] wdata_p1, wdata_nxt;
  logic [1:0]  size_p1, size_nxt;
  logic        signed_p1, signed_nxt;
  logic        split_p1, split_nxt;
  logic [1:0]  wr_idx_p1, wr_idx_nxt;
  logic [1:0]  wr_last_p1, wr_last_nxt;
  logic [31:0] lo_p2, lo_nxt;

  logic [1:0]  req_size_n;
  logic        req_native;
  logic [1:0]  wr_idx_inc;
  logic [31:0] merge_rdata;

  assign req_size_n = norm_size(req_size);
  assign req_native = is_native(req_addr[1:0], req_size_n);
  assign wr_idx_inc = wr_idx_p1 + 2'd1;

  mem_load_merge u_merge (
    .lo        (lo_p2),
    .hi        (ram_r_data),
    .offset    (addr_p1[1:0]),
    .size      (size_p1),
    .is_signed (signed_p1),
    .rdata     (merge_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    resp_valid_nxt  = 1'b0;
    resp_err_nxt    = 1'b0;
    resp_rdata_nxt  = resp_rdata;
    ram_we_nxt      = 1'b0;
    ram_r_addr_nxt  = ram_r_addr;
    ram_w_addr_nxt  = ram_w_addr;
    ram_w_data_nxt  = ram_w_data;
    ram_rmode_nxt   = ram_rmode;
    ram_wmode_nxt   = ram_wmode;
    ram_rsigned_nxt = ram_rsigned;
    addr_nxt        = addr_p1;
    wdata_nxt       = wdata_p1;
    size_nxt        = size_p1;
    signed_nxt      = signed_p1;
    split_nxt       = split_p1;
    wr_idx_nxt      = wr_idx_p1;
    wr_last_nxt     = wr_last_p1;
    lo_nxt          = lo_p2;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          addr_nxt   = req_addr;
          wdata_nxt  = req_wdata;
          size_nxt   = req_size_n;
          signed_nxt = req_signed;
          split_nxt  = !req_native;
          if (!req_native && !ALLOW_MISALIGNED) begin
            state_nxt = ST_RESP;
          end else if (req_we) begin
            ram_we_nxt     = 1'b1;
            ram_w_addr_nxt = req_addr;
            wr_idx_nxt     = 2'd0;
            if (req_native) begin
              ram_w_data_nxt = req_wdata;
              ram_wmode_nxt  = req_size_n;
              wr_last_nxt    = 2'd0;
            end else begin
              ram_w_data_nxt = {24'h0, req_wdata[7:0]};
              ram_wmode_nxt  = RAM_MODE_BYTE;
              wr_last_nxt    = last_byte_idx(req_size_n);
            end
            state_nxt = ST_WR;
          end else begin
            if (req_native) begin
              ram_r_addr_nxt  = req_addr;
              ram_rmode_nxt   = req_size_n;
              ram_rsigned_nxt = req_signed;
            end else begin
              // Split loads fetch whole words; extension happens in the merge.
              ram_r_addr_nxt  = {req_addr[31:2], 2'b00};
              ram_rmode_nxt   = RAM_MODE_WORD;
              ram_rsigned_nxt = 1'b0;
            end
            state_nxt = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (split_p1) begin
          lo_nxt         = ram_r_data;
          ram_r_addr_nxt = ram_r_addr + 32'd4;
          state_nxt      = ST_RD2;
        end else begin
          resp_rdata_nxt = ram_r_data;
          resp_valid_nxt = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end

      ST_RD2: begin
        resp_rdata_nxt = merge_rdata;
        resp_valid_nxt = 1'b1;
        state_nxt      = ST_IDLE;
      end

      ST_WR: begin
        if (wr_idx_p1 == wr_last_p1) begin
          resp_rdata_nxt = 32'h0;
          resp_valid_nxt = 1'b1;
          state_nxt      = ST_IDLE;
        end else begin
          wr_idx_nxt     = wr_idx_inc;
          ram_we_nxt     = 1'b1;
          ram_w_addr_nxt = addr_p1 + {30'd0, wr_idx_inc};
          ram_w_data_nxt = {24'h0, wdata_p1[{wr_idx_inc, 3'b000} +: 8]};
          ram_wmode_nxt  = RAM_MODE_BYTE;
        end
      end

      ST_RESP: begin
        resp_rdata_nxt = 32'h0;
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = 1'b1;
        state_nxt      = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
  end

  // Registered outputs and control: reset to the idle, no-access state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'h0;
      ram_we      <= 1'b0;
      ram_r_addr  <= 32'h0;
      ram_w_addr  <= 32'h0;
      ram_w_data  <= 32'h0;
      ram_rmode   <= 2'b00;
      ram_wmode   <= 2'b00;
      ram_rsigned <= 1'b0;
      split_p1    <= 1'b0;
      wr_idx_p1   <= 2'd0;
      wr_last_p1  <= 2'd0;
    end else begin
      req_ready   <= ready_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_err    <= resp_err_nxt;
      resp_rdata  <= resp_rdata_nxt;
      ram_we      <= ram_we_nxt;
      ram_r_addr  <= ram_r_addr_nxt;
      ram_w_addr  <= ram_w_addr_nxt;
      ram_w_data  <= ram_w_data_nxt;
      ram_rmode   <= ram_rmode_nxt;
      ram_wmode   <= ram_wmode_nxt;
      ram_rsigned <= ram_rsigned_nxt;
      split_p1    <= split_nxt;
      wr_idx_p1   <= wr_idx_nxt;
      wr_last_p1  <= wr_last_nxt;
    end
  end

  // Captured request and low load word: data only, no reset.
  always_ff @(posedge clk) begin
    addr_p1   <= addr_nxt;
    wdata_p1  <= wdata_nxt;
    size_p1   <= size_nxt;
    signed_p1 <= signed_nxt;
    lo_p2     <= lo_nxt;
  end

endmodule
